// File: rtl/drum_voice.sv
// Synthetic drum hit: square wave with upward half-period sweep, a constant
// hold phase, then exponential amplitude decay, one sample per advance strobe.
module drum_voice #(
   parameter logic [23:0] AMP_INIT     = 24'd4000000,
   parameter logic [15:0] HALF_START   = 16'd55,
   parameter logic [15:0] HALF_END     = 16'd110,
   parameter logic [15:0] SWEEP_STEP   = 16'd2,
   parameter logic [15:0] HOLD_SAMPLES = 16'd480,
   parameter logic [3:0]  DECAY_SHIFT  = 4'd6
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        advance,
   input  logic        trigger,
   output logic [23:0] aud_out,
   output logic        sample_valid,
   output logic        active
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      DECAY = 2'd2
   } state_t;

   state_t      state, state_nx, state_b;
   logic [22:0] amp, amp_nx, amp_b, amp_step, amp_dec;
   logic        polarity, polarity_nx, polarity_b;
   logic [15:0] phase_cnt, phase_nx, phase_b;
   logic [15:0] cur_half, half_nx, half_b, half_sat;
   logic [16:0] half_sum;
   logic [15:0] hold_cnt, hold_nx, hold_b;
   logic [23:0] aud_nx;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         amp          <= '0;
         polarity     <= 1'b1;
         phase_cnt    <= '0;
         cur_half     <= HALF_START;
         hold_cnt     <= '0;
         aud_out      <= '0;
         sample_valid <= 1'b0;
      end else begin
         state        <= state_nx;
         amp          <= amp_nx;
         polarity     <= polarity_nx;
         phase_cnt    <= phase_nx;
         cur_half     <= half_nx;
         hold_cnt     <= hold_nx;
         aud_out      <= aud_nx;
         sample_valid <= advance;
      end
   end

   always_comb begin
      // A trigger first reloads the voice; a coincident advance then runs
      // as the first HOLD sample on top of the reloaded values.
      state_b    = state;
      amp_b      = amp;
      polarity_b = polarity;
      phase_b    = phase_cnt;
      half_b     = cur_half;
      hold_b     = hold_cnt;
      if (trigger) begin
         state_b    = HOLD;
         amp_b      = AMP_INIT[22:0];
         polarity_b = 1'b1;
         phase_b    = '0;
         half_b     = HALF_START;
         hold_b     = '0;
      end

      state_nx    = state_b;
      amp_nx      = amp_b;
      polarity_nx = polarity_b;
      phase_nx    = phase_b;
      half_nx     = half_b;
      hold_nx     = hold_b;
      aud_nx      = aud_out;

      half_sum = {1'b0, half_b} + {1'b0, SWEEP_STEP};
      half_sat = (half_sum > {1'b0, HALF_END}) ? HALF_END : half_sum[15:0];
      amp_step = amp_b >> DECAY_SHIFT;
      if (amp_step == '0)
         amp_step = 23'd1;
      amp_dec = amp_b - amp_step;

      if (advance) begin
         if (state_b == IDLE) begin
            aud_nx = '0;
         end else begin
            aud_nx = polarity_b ? {1'b0, amp_b} : (24'd0 - {1'b0, amp_b});
            if (phase_b == half_b - 16'd1) begin
               phase_nx    = '0;
               polarity_nx = ~polarity_b;
               half_nx     = half_sat;
            end else begin
               phase_nx = phase_b + 16'd1;
            end
            if (state_b == HOLD) begin
               hold_nx = hold_b + 16'd1;
               if (hold_b == HOLD_SAMPLES - 16'd1)
                  state_nx = DECAY;
            end else begin
               amp_nx = amp_dec;
               if (amp_dec == '0)
                  state_nx = IDLE;
            end
         end
      end
   end

   assign active = (state != IDLE);

endmodule

// File: tb/tb_drum_voice.sv
// Directed vector bench for drum_voice with small parameters so every sample
// of a hit can be written out by hand.
module tb_drum_voice;

   logic        CLOCK_50 = 1'b0;
   logic        reset    = 1'b0;
   logic        advance  = 1'b0;
   logic        trigger  = 1'b0;
   logic [23:0] aud_out;
   logic        sample_valid;
   logic        active;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   drum_voice #(
      .AMP_INIT    (24'd1000),
      .HALF_START  (16'd4),
      .HALF_END    (16'd6),
      .SWEEP_STEP  (16'd1),
      .HOLD_SAMPLES(16'd3),
      .DECAY_SHIFT (4'd1)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .advance     (advance),
      .trigger     (trigger),
      .aud_out     (aud_out),
      .sample_valid(sample_valid),
      .active      (active)
   );

   typedef struct {
      logic        trig;
      logic        adv;
      logic [23:0] aud;
      logic        valid;
      logic        act;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic void add(input logic t, input logic a, input logic [23:0] aud,
                               input logic v, input logic act, input string name);
      vec_t x;
      x.trig = t; x.adv = a; x.aud = aud; x.valid = v; x.act = act; x.name = name;
      vecs.push_back(x);
   endfunction

   initial begin
      // reset idle stream
      for (int i = 0; i < 3; i++) add(0, 1, 24'd0, 1, 0, "idle_adv");
      // full hit
      add(1, 0, 24'd0, 0, 1, "trig");
      add(0, 1, 24'd1000, 1, 1, "s1");
      add(0, 1, 24'd1000, 1, 1, "s2");
      add(0, 1, 24'd1000, 1, 1, "s3");
      add(0, 1, 24'd1000, 1, 1, "s4");
      add(0, 1, -24'sd500, 1, 1, "s5");
      add(0, 1, -24'sd250, 1, 1, "s6");
      add(0, 1, -24'sd125, 1, 1, "s7");
      add(0, 1, -24'sd63, 1, 1, "s8");
      add(0, 1, -24'sd32, 1, 1, "s9");
      add(0, 1, 24'd16, 1, 1, "s10");
      add(0, 1, 24'd8, 1, 1, "s11");
      add(0, 1, 24'd4, 1, 1, "s12");
      add(0, 1, 24'd2, 1, 1, "s13");
      add(0, 1, 24'd1, 1, 0, "s14");
      add(0, 1, 24'd0, 1, 0, "s15");
      // retrigger in decay
      add(1, 0, 24'd0, 0, 1, "trig2");
      add(0, 1, 24'd1000, 1, 1, "r1");
      add(0, 1, 24'd1000, 1, 1, "r2");
      add(0, 1, 24'd1000, 1, 1, "r3");
      add(0, 1, 24'd1000, 1, 1, "r4");
      add(0, 1, -24'sd500, 1, 1, "r5");
      add(0, 1, -24'sd250, 1, 1, "r6");
      add(0, 1, -24'sd125, 1, 1, "r7");
      add(1, 0, -24'sd125, 0, 1, "retrig");
      add(0, 1, 24'd1000, 1, 1, "q1");
      add(0, 1, 24'd1000, 1, 1, "q2");
      add(0, 1, 24'd1000, 1, 1, "q3");
      add(0, 1, 24'd1000, 1, 1, "q4");
      add(0, 1, -24'sd500, 1, 1, "q5");
      // trigger and advance together
      add(1, 1, 24'h0003E8, 1, 1, "ta1");
      add(0, 1, 24'd1000, 1, 1, "ta2");
      add(0, 1, 24'd1000, 1, 1, "ta3");
      add(0, 1, 24'd1000, 1, 1, "ta4");
      add(0, 1, -24'sd500, 1, 1, "ta5");
      add(0, 1, -24'sd250, 1, 1, "ta6");
      add(0, 1, -24'sd125, 1, 1, "ta7");

      // reset state
      #12;
      check("rst_aud", aud_out, 24'd0);
      check("rst_valid", {23'd0, sample_valid}, 24'd0);
      check("rst_active", {23'd0, active}, 24'd0);
      @(negedge CLOCK_50);
      reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge CLOCK_50);
         trigger = vecs[i].trig;
         advance = vecs[i].adv;
         @(negedge CLOCK_50);
         trigger = 1'b0;
         advance = 1'b0;
         check({vecs[i].name, "_aud"}, aud_out, vecs[i].aud);
         check({vecs[i].name, "_valid"}, {23'd0, sample_valid}, {23'd0, vecs[i].valid});
         check({vecs[i].name, "_active"}, {23'd0, active}, {23'd0, vecs[i].act});
         @(negedge CLOCK_50);
         check({vecs[i].name, "_gap_valid"}, {23'd0, sample_valid}, 24'd0);
         check({vecs[i].name, "_gap_aud"}, aud_out, vecs[i].aud);
      end

      // asynchronous reset mid-decay, output currently -125
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_aud", aud_out, 24'd0);
      check("async_rst_active", {23'd0, active}, 24'd0);
      @(negedge CLOCK_50);
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLOCK_50);
         advance = 1'b1;
         @(negedge CLOCK_50);
         advance = 1'b0;
         check("post_rst_aud", aud_out, 24'd0);
         check("post_rst_valid", {23'd0, sample_valid}, 24'd1);
         check("post_rst_active", {23'd0, active}, 24'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
